// File: rtl/btn_gesture_pkg.sv
// rtl/btn_gesture_pkg.sv - shared helpers for the button gesture decoder
package btn_gesture_pkg;

   // Larger of two tick thresholds; sizes the shared tick counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_gesture_tick_gen.sv
// rtl/btn_gesture_tick_gen.sv - prescaler producing one tick every DIV clocks
module tick_gen #(
   parameter int DIV = 12000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt_q;

   assign tick_o = (cnt_q == W'(DIV - 1));

   // Count 0..DIV-1; a clear restarts the period so timing is relative to state entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/btn_gesture.sv
// rtl/btn_gesture.sv - turns a filtered button level into short/double/long events
module btn_gesture
   import btn_gesture_pkg::*;
#(
   parameter int TICK_DIV       = 12000,
   parameter int LONG_TICKS     = 800,
   parameter int DBL_TICKS      = 300,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic btn_val,
   output logic pressed,
   output logic evt_short,
   output logic evt_double,
   output logic evt_long
);

   localparam int TMAX = max_int(LONG_TICKS, DBL_TICKS);
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PRESS1    = 3'd1,
      S_WAIT2     = 3'd2,
      S_PRESS2    = 3'd3,
      S_LONG_HELD = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          p, p_prev_q, press_edge, release_edge;
   logic          tick, tclr, t_long, t_dbl;
   logic [TW-1:0] tcnt_q;
   logic          evt_short_d, evt_double_d, evt_long_d;
   logic          evt_short_q, evt_double_q, evt_long_q, pressed_q;

   // Normalise polarity so p = 1 always means "button held".
   assign p            = btn_val ^ BTN_ACTIVE_LOW;
   assign press_edge   = p & ~p_prev_q;
   assign release_edge = ~p & p_prev_q;

   // Timers restart on every state change and are held clear while disarmed.
   assign tclr   = (state_d != state_q) | ~en;
   assign t_long = tick & (tcnt_q == TW'(LONG_TICKS - 1));
   assign t_dbl  = tick & (tcnt_q == TW'(DBL_TICKS - 1));

   tick_gen #(
      .DIV(TICK_DIV)
   ) u_tick_gen (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (tclr),
      .tick_o(tick)
   );

   // Tick counter, saturating so a long idle never wraps into a false timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= '0;
      end else if (tclr) begin
         tcnt_q <= '0;
      end else if (tick && (tcnt_q != TW'(TMAX))) begin
         tcnt_q <= tcnt_q + 1'b1;
      end
   end

   // Next-state and event decode; edges are checked before timeouts so an edge wins.
   always_comb begin
      state_d      = state_q;
      evt_short_d  = 1'b0;
      evt_double_d = 1'b0;
      evt_long_d   = 1'b0;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (press_edge) state_d = S_PRESS1;
            end
            S_PRESS1: begin
               if (release_edge) begin
                  state_d = S_WAIT2;
               end else if (t_long) begin
                  state_d    = S_LONG_HELD;
                  evt_long_d = 1'b1;
               end
            end
            S_WAIT2: begin
               if (press_edge) begin
                  state_d = S_PRESS2;
               end else if (t_dbl) begin
                  state_d     = S_IDLE;
                  evt_short_d = 1'b1;
               end
            end
            S_PRESS2: begin
               if (release_edge) begin
                  state_d      = S_IDLE;
                  evt_double_d = 1'b1;
               end else if (t_long) begin
                  state_d      = S_LONG_HELD;
                  evt_double_d = 1'b1;
               end
            end
            S_LONG_HELD: begin
               if (release_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, level history and registered outputs advance together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         p_prev_q     <= 1'b0;
         pressed_q    <= 1'b0;
         evt_short_q  <= 1'b0;
         evt_double_q <= 1'b0;
         evt_long_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         p_prev_q     <= p;
         pressed_q    <= (state_d == S_PRESS1) || (state_d == S_PRESS2) ||
                         (state_d == S_LONG_HELD);
         evt_short_q  <= evt_short_d;
         evt_double_q <= evt_double_d;
         evt_long_q   <= evt_long_d;
      end
   end

   assign pressed    = pressed_q;
   assign evt_short  = evt_short_q;
   assign evt_double = evt_double_q;
   assign evt_long   = evt_long_q;

endmodule

// File: tb/tb_btn_gesture.sv
// tb/tb_btn_gesture.sv - randomized and directed checks of btn_gesture against a timing model
module tb_btn_gesture;

   localparam int DIV  = 4;
   localparam int LONG = 5;
   localparam int DBL  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic btn_val = 1'b1;
   logic pressed, evt_short, evt_double, evt_long;

   int vectors = 0;
   int miscompares = 0;

   // Model: gesture phase plus the number of cycles spent in it.
   // Phases: 0 released/idle, 1 first hold, 2 gap after first release, 3 second hold, 4 long hold.
   int m_mode = 0;
   int m_age = 0;
   bit m_prev = 1'b0;
   logic exp_pressed = 1'b0, exp_short = 1'b0, exp_double = 1'b0, exp_long = 1'b0;

   btn_gesture #(
      .TICK_DIV(DIV), .LONG_TICKS(LONG), .DBL_TICKS(DBL), .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .btn_val(btn_val),
      .pressed(pressed), .evt_short(evt_short), .evt_double(evt_double), .evt_long(evt_long)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] obs();
      return {pressed, evt_short, evt_double, evt_long};
   endfunction

   function automatic logic [3:0] want();
      return {exp_pressed, exp_short, exp_double, exp_long};
   endfunction

   // One rising edge of the model: a deadline of N ticks is N*DIV cycles after entering a phase.
   task automatic model_step();
      bit pr, pe, re;
      int nxt;
      exp_short = 0; exp_double = 0; exp_long = 0;
      if (rst) begin
         m_mode = 0; m_age = 0; m_prev = 0; exp_pressed = 0;
         return;
      end
      pr = ~btn_val;
      pe = pr & ~m_prev;
      re = ~pr & m_prev;
      m_prev = pr;
      nxt = m_mode;
      if (!en) nxt = 0;
      else begin
         case (m_mode)
            0: if (pe) nxt = 1;
            1: if (re) nxt = 2;
               else if (m_age == LONG*DIV-1) begin nxt = 4; exp_long = 1; end
            2: if (pe) nxt = 3;
               else if (m_age == DBL*DIV-1) begin nxt = 0; exp_short = 1; end
            3: if (re) begin nxt = 0; exp_double = 1; end
               else if (m_age == LONG*DIV-1) begin nxt = 4; exp_double = 1; end
            4: if (re) nxt = 0;
            default: nxt = 0;
         endcase
      end
      if (nxt != m_mode || !en) m_age = 0;
      else if (m_age < 1000000) m_age++;
      m_mode = nxt;
      exp_pressed = (m_mode == 1 || m_mode == 3 || m_mode == 4);
   endtask

   // Apply inputs for one cycle (from a falling edge) and land on the next falling edge.
   task automatic step(input logic b, input logic e);
      btn_val = b;
      en = e;
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int nev;
      rst = 1; btn_val = 1; en = 1;
      model_step();
      @(negedge clk); @(negedge clk);
      vectors++;
      if (obs() !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b required 0000", obs());
      end
      rst = 0;
      nev = 0;
      for (int i = 0; i < 100; i++) begin
         step(1, 1);
         vectors++;
         if (obs() !== want()) begin
            miscompares++;
            $display("FAIL reset_idle cyc %0d: got %b required %b", i, obs(), want());
         end
         nev += evt_short + evt_double + evt_long;
      end
      vectors++;
      if (nev !== 0) begin
         miscompares++;
         $display("FAIL reset_idle_events: got %0d required 0", nev);
      end
   endtask

   task automatic test_short();
      int n, at;
      for (int i = 0; i < 8; i++) begin
         step(0, 1);
         vectors++;
         if (pressed !== 1'b1 || obs() !== want()) begin
            miscompares++;
            $display("FAIL short_hold cyc %0d: got %b required %b", i, obs(), want());
         end
      end
      step(1, 1);
      n = 0; at = -1;
      for (int k = 1; k <= 20; k++) begin
         step(1, 1);
         vectors++;
         if (obs() !== want()) begin
            miscompares++;
            $display("FAIL short_wait cyc %0d: got %b required %b", k, obs(), want());
         end
         if (evt_short) begin n++; at = k; end
      end
      vectors++;
      if (n !== 1 || at !== 12) begin
         miscompares++;
         $display("FAIL short_timing: got count %0d at %0d required count 1 at 12", n, at);
      end
   endtask

   task automatic test_long();
      int n, at, nev;
      step(0, 1);
      n = 0; at = -1;
      for (int k = 1; k <= 25; k++) begin
         step(0, 1);
         vectors++;
         if (obs() !== want()) begin
            miscompares++;
            $display("FAIL long_hold cyc %0d: got %b required %b", k, obs(), want());
         end
         if (evt_long) begin n++; at = k; end
      end
      vectors++;
      if (n !== 1 || at !== 20 || pressed !== 1'b1) begin
         miscompares++;
         $display("FAIL long_timing: got count %0d at %0d pressed %b required count 1 at 20 pressed 1",
                  n, at, pressed);
      end
      nev = 0;
      for (int k = 0; k < 15; k++) begin
         step(1, 1);
         nev += evt_short + evt_double + evt_long;
      end
      vectors++;
      if (pressed !== 1'b0 || nev !== 0) begin
         miscompares++;
         $display("FAIL long_release: got pressed %b events %0d required pressed 0 events 0",
                  pressed, nev);
      end
   endtask

   task automatic test_double();
      int ns, nd, nl;
      ns = 0; nd = 0; nl = 0;
      for (int i = 0; i < 30; i++) begin
         step((i < 6 || (i >= 10 && i < 16)) ? 1'b0 : 1'b1, 1);
         vectors++;
         if (obs() !== want()) begin
            miscompares++;
            $display("FAIL double_seq cyc %0d: got %b required %b", i, obs(), want());
         end
         ns += evt_short; nd += evt_double; nl += evt_long;
      end
      vectors++;
      if (ns !== 0 || nd !== 1 || nl !== 0) begin
         miscompares++;
         $display("FAIL double_count: got s/d/l %0d/%0d/%0d required 0/1/0", ns, nd, nl);
      end
   endtask

   task automatic test_edge_wins();
      int ns, nd;
      ns = 0; nd = 0;
      for (int i = 0; i < 6; i++) step(0, 1);
      step(1, 1);
      for (int i = 0; i < 11; i++) begin
         step(1, 1);
         ns += evt_short;
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 1);
         vectors++;
         if (obs() !== want()) begin
            miscompares++;
            $display("FAIL edge_wins cyc %0d: got %b required %b", i, obs(), want());
         end
         ns += evt_short; nd += evt_double;
      end
      for (int i = 0; i < 20; i++) begin
         step(1, 1);
         ns += evt_short; nd += evt_double;
      end
      vectors++;
      if (ns !== 0 || nd !== 1) begin
         miscompares++;
         $display("FAIL edge_wins_count: got short %0d double %0d required 0 and 1", ns, nd);
      end
   endtask

   task automatic test_en_drop();
      int nev, ns;
      for (int i = 0; i < 3; i++) step(0, 1);
      step(0, 0);
      vectors++;
      if (pressed !== 1'b0) begin
         miscompares++;
         $display("FAIL en_drop_pressed: got %b required 0", pressed);
      end
      for (int i = 0; i < 3; i++) step(0, 0);
      nev = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, 1);
         vectors++;
         if (obs() !== want()) begin
            miscompares++;
            $display("FAIL en_held cyc %0d: got %b required %b", i, obs(), want());
         end
         nev += pressed + evt_short + evt_double + evt_long;
      end
      vectors++;
      if (nev !== 0) begin
         miscompares++;
         $display("FAIL en_held_quiet: got %0d activity required 0", nev);
      end
      step(1, 1); step(1, 1);
      ns = 0;
      for (int i = 0; i < 25; i++) begin
         step((i < 6) ? 1'b0 : 1'b1, 1);
         ns += evt_short;
      end
      vectors++;
      if (ns !== 1) begin
         miscompares++;
         $display("FAIL en_fresh_short: got %0d required 1", ns);
      end
   endtask

   task automatic test_rst_mid();
      int nev;
      for (int i = 0; i < 3; i++) step(0, 1);
      rst = 1;
      #1;
      vectors++;
      if (pressed !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_pressed: got %b required 0", pressed);
      end
      step(1, 1);
      rst = 0;
      nev = 0;
      for (int i = 0; i < 30; i++) begin
         step(1, 1);
         vectors++;
         if (obs() !== want()) begin
            miscompares++;
            $display("FAIL rst_mid_after cyc %0d: got %b required %b", i, obs(), want());
         end
         nev += evt_short + evt_double + evt_long;
      end
      vectors++;
      if (nev !== 0) begin
         miscompares++;
         $display("FAIL rst_mid_quiet: got %0d events required 0", nev);
      end
   endtask

   task automatic test_random();
      logic b, e;
      int len, cyc;
      cyc = 0;
      while (cyc < 3000) begin
         b = $urandom_range(0, 1);
         e = ($urandom_range(0, 15) != 0);
         len = $urandom_range(1, 30);
         for (int i = 0; i < len; i++) begin
            rst = ($urandom_range(0, 255) == 0);
            step(b, e);
            if (rst) begin
               rst = 0;
               #1;
            end
            vectors++;
            if (obs() !== want()) begin
               miscompares++;
               $display("FAIL random cyc %0d: got %b required %b", cyc, obs(), want());
            end
            cyc++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_double();
      test_edge_wins();
      test_en_drop();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
